// File: rtl/sar_result_fifo.sv
// sar_result_fifo: captures SAR conversion results on the rising edge of eoc,
// averages groups of 2^AVG_LOG2 samples and queues the averages in a small
// circular FIFO with a valid/ready output and a sticky overflow flag.
module sar_result_fifo #(
    parameter int AVG_LOG2   = 2,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic [7:0]            sar_in,
    input  logic                  eoc,
    output logic [7:0]            out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DEPTH_LOG2:0]   fill,
    output logic                  overflow
);

    // Widths and constants. The sample counter keeps at least one bit so the
    // pass-through case (AVG_LOG2=0) needs no special structure: its last
    // count is 0, so every capture completes a group.
    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam int ACC_W  = 8 + AVG_LOG2;
    localparam int CNT_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int FILL_W = DEPTH_LOG2 + 1;

    localparam logic [CNT_W-1:0]  LAST_CNT   = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [FILL_W-1:0] FULL_COUNT = FILL_W'(DEPTH);

    // State registers
    logic                  eoc_prev_q, eoc_prev_d;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [FILL_W-1:0]     fill_q, fill_d;
    logic                  overflow_q, overflow_d;

    // FIFO storage, intentionally not reset
    logic [7:0]            mem_q [DEPTH];

    // Datapath intermediates
    logic                  capture;
    logic                  group_done;
    logic [ACC_W-1:0]      sum;
    logic [ACC_W-1:0]      avg_full;
    logic [7:0]            push_data;
    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  push_ok;
    logic                  drop;

    // Rising-edge detect on eoc, accumulation and group completion.
    // A group completes on the capture that finds the counter at its last
    // value; the accumulator and counter then restart from zero.
    always_comb begin
        eoc_prev_d = eoc;
        capture    = eoc && !eoc_prev_q;
        group_done = capture && (cnt_q == LAST_CNT);
        sum        = acc_q + ACC_W'(sar_in);
        avg_full   = sum >> AVG_LOG2;
        push_data  = avg_full[7:0];
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        if (clr) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (group_done) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (capture) begin
            acc_d = sum;
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // FIFO control: a push into a full FIFO is only accepted when the head
    // leaves on the same edge; otherwise the value is lost and flagged.
    always_comb begin
        full     = (fill_q == FULL_COUNT);
        push     = group_done && !clr;
        pop      = out_valid && out_ready && !clr;
        push_ok  = push && (!full || pop);
        drop     = push && full && !pop;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        overflow_d = overflow_q;
        if (clr) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fill_d     = '0;
            overflow_d = 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
            end
            if (push_ok && !pop) begin
                fill_d = fill_q + FILL_W'(1);
            end else if (pop && !push_ok) begin
                fill_d = fill_q - FILL_W'(1);
            end
            if (drop) begin
                overflow_d = 1'b1;
            end
        end
    end

    // Control and datapath state, cleared asynchronously on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eoc_prev_q <= 1'b0;
            acc_q      <= '0;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            eoc_prev_q <= eoc_prev_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fill_q     <= fill_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage write; stale contents are never visible because the head is
    // masked while the FIFO is empty
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Outputs come straight from registers; out_ready never reaches out_data
    always_comb begin
        out_valid = (fill_q != '0);
        out_data  = out_valid ? mem_q[rd_ptr_q] : 8'h00;
        fill      = fill_q;
        overflow  = overflow_q;
    end

endmodule

// File: tb/tb_sar_result_fifo.sv
// Bench for sar_result_fifo: one pass-through instance (AVG_LOG2=0) and one
// averaging instance (AVG_LOG2=2), each with its own expected-value queue and
// an independent monitor that checks every head the DUT hands over.
module tb_sar_result_fifo;

    logic       clk;
    logic       rst0, clr0, eoc0, rdy0;
    logic [7:0] sar0;
    logic [7:0] out_data0;
    logic       out_valid0, overflow0;
    logic [2:0] fill0;

    logic       rst2, clr2, eoc2, rdy2;
    logic [7:0] sar2;
    logic [7:0] out_data2;
    logic       out_valid2, overflow2;
    logic [2:0] fill2;

    int checks;
    int passes;

    logic [7:0] exp0 [$];
    logic [7:0] exp2 [$];

    sar_result_fifo #(.AVG_LOG2(0), .DEPTH_LOG2(2)) dut0 (
        .clk(clk), .rst(rst0), .clr(clr0), .sar_in(sar0), .eoc(eoc0),
        .out_data(out_data0), .out_valid(out_valid0), .out_ready(rdy0),
        .fill(fill0), .overflow(overflow0)
    );

    sar_result_fifo #(.AVG_LOG2(2), .DEPTH_LOG2(2)) dut2 (
        .clk(clk), .rst(rst2), .clr(clr2), .sar_in(sar2), .eoc(eoc2),
        .out_data(out_data2), .out_valid(out_valid2), .out_ready(rdy2),
        .fill(fill2), .overflow(overflow2)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // One eoc pulse: a low cycle, then eoc high for 'hold' edges. Returns 1ns
    // after the capture edge (for hold=1), with eoc back low.
    task automatic applyStimulus(input int sel, input logic [7:0] v, input int hold);
        @(posedge clk); #1;
        if (sel == 0) begin sar0 = v; eoc0 = 1'b1; end
        else          begin sar2 = v; eoc2 = 1'b1; end
        repeat (hold) @(posedge clk);
        #1;
        if (sel == 0) eoc0 = 1'b0;
        else          eoc2 = 1'b0;
    endtask

    // Let the consumer accept until the FIFO is empty, with a cycle budget
    task automatic drainFifo(input int sel);
        int n;
        n = 0;
        if (sel == 0) rdy0 = 1'b1; else rdy2 = 1'b1;
        while (((sel == 0) ? fill0 : fill2) != 3'd0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (sel == 0) rdy0 = 1'b0; else rdy2 = 1'b0;
        checkOutput((sel == 0) ? "drain0_empty" : "drain2_empty",
                    int'((sel == 0) ? fill0 : fill2), 0);
    endtask

    task automatic pulseClr(input int sel);
        @(posedge clk); #1;
        if (sel == 0) clr0 = 1'b1; else clr2 = 1'b1;
        @(posedge clk); #1;
        if (sel == 0) clr0 = 1'b0; else clr2 = 1'b0;
    endtask

    // Monitors: a pop happens on the next rising edge whenever valid and
    // ready are both high here, so the head is compared with the oldest
    // expected entry.
    always @(negedge clk) begin
        if (!rst0 && !clr0 && out_valid0 && rdy0) begin
            if (exp0.size() == 0) begin
                checks++;
                $display("[TB] FAIL sb0_unexpected: got %0d, expected no entry", out_data0);
            end else begin
                checkOutput("sb0_data", int'(out_data0), int'(exp0.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst2 && !clr2 && out_valid2 && rdy2) begin
            if (exp2.size() == 0) begin
                checks++;
                $display("[TB] FAIL sb2_unexpected: got %0d, expected no entry", out_data2);
            end else begin
                checkOutput("sb2_data", int'(out_data2), int'(exp2.pop_front()));
            end
        end
    end

    initial begin
        logic [7:0] pt [3];
        checks = 0;
        passes = 0;
        rst0 = 1'b1; clr0 = 1'b0; eoc0 = 1'b0; rdy0 = 1'b0; sar0 = 8'h00;
        rst2 = 1'b1; clr2 = 1'b0; eoc2 = 1'b0; rdy2 = 1'b0; sar2 = 8'h00;
        #22;
        rst0 = 1'b0;
        rst2 = 1'b0;
        #1;

        $display("[TB] reset state");
        checkOutput("rst0_valid", int'(out_valid0), 0);
        checkOutput("rst0_data", int'(out_data0), 0);
        checkOutput("rst0_fill", int'(fill0), 0);
        checkOutput("rst0_ovf", int'(overflow0), 0);
        checkOutput("rst2_fill", int'(fill2), 0);

        $display("[TB] pass-through");
        pt[0] = 8'h5A; pt[1] = 8'h00; pt[2] = 8'hFF;
        rdy0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp0.push_back(pt[i]);
            applyStimulus(0, pt[i], 1);
            checkOutput("pt_valid", int'(out_valid0), 1);
            checkOutput("pt_data", int'(out_data0), int'(pt[i]));
        end
        @(posedge clk); #1;
        rdy0 = 1'b0;
        checkOutput("pt_ovf", int'(overflow0), 0);
        checkOutput("pt_fill", int'(fill0), 0);

        $display("[TB] averaging");
        applyStimulus(2, 8'd10, 1);
        applyStimulus(2, 8'd11, 1);
        applyStimulus(2, 8'd12, 1);
        checkOutput("avg_fill_before", int'(fill2), 0);
        exp2.push_back(8'd11);
        applyStimulus(2, 8'd13, 1);
        checkOutput("avg_fill_after", int'(fill2), 1);
        checkOutput("avg_head", int'(out_data2), 11);
        exp2.push_back(8'd255);
        for (int i = 0; i < 4; i++) applyStimulus(2, 8'd255, 1);
        checkOutput("avg_fill_two", int'(fill2), 2);
        drainFifo(2);

        $display("[TB] long eoc");
        exp0.push_back(8'h33);
        applyStimulus(0, 8'h33, 6);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("long_fill", int'(fill0), 1);
        checkOutput("long_head", int'(out_data0), 8'h33);
        drainFifo(0);

        $display("[TB] overflow");
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) exp0.push_back(8'(i));
            applyStimulus(0, 8'(i), 1);
        end
        checkOutput("ovf_fill", int'(fill0), 4);
        checkOutput("ovf_flag", int'(overflow0), 1);
        drainFifo(0);
        checkOutput("ovf_sticky", int'(overflow0), 1);
        pulseClr(0);
        checkOutput("ovf_cleared", int'(overflow0), 0);

        $display("[TB] full with simultaneous pop");
        for (int i = 1; i <= 4; i++) begin
            exp0.push_back(8'(i));
            applyStimulus(0, 8'(i), 1);
        end
        exp0.push_back(8'd5);
        @(posedge clk); #1;
        sar0 = 8'd5; eoc0 = 1'b1; rdy0 = 1'b1;
        @(posedge clk); #1;
        eoc0 = 1'b0; rdy0 = 1'b0;
        checkOutput("fp_fill", int'(fill0), 4);
        checkOutput("fp_ovf", int'(overflow0), 0);
        checkOutput("fp_head", int'(out_data0), 2);
        drainFifo(0);

        $display("[TB] reset mid-group");
        applyStimulus(2, 8'd100, 1);
        applyStimulus(2, 8'd100, 1);
        #1 rst2 = 1'b1;
        #2 rst2 = 1'b0;
        checkOutput("rstmid_fill", int'(fill2), 0);
        checkOutput("rstmid_data", int'(out_data2), 0);
        exp2.push_back(8'd4);
        for (int i = 0; i < 4; i++) applyStimulus(2, 8'd4, 1);
        checkOutput("rstmid_count", int'(fill2), 1);
        checkOutput("rstmid_head", int'(out_data2), 4);
        drainFifo(2);

        $display("[TB] clear mid-group");
        for (int i = 0; i < 4; i++) applyStimulus(2, 8'd8, 1);
        applyStimulus(2, 8'd100, 1);
        applyStimulus(2, 8'd100, 1);
        pulseClr(2);
        checkOutput("clr_fill", int'(fill2), 0);
        checkOutput("clr_valid", int'(out_valid2), 0);
        exp2.push_back(8'd4);
        for (int i = 0; i < 4; i++) applyStimulus(2, 8'd4, 1);
        checkOutput("clr_count", int'(fill2), 1);
        checkOutput("clr_head", int'(out_data2), 4);
        drainFifo(2);

        repeat (2) @(posedge clk);
        checkOutput("sb0_all_seen", exp0.size(), 0);
        checkOutput("sb2_all_seen", exp2.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/sar_result_fifo.md
# sar_result_fifo

Downstream consumer of the 8-bit SAR conversion engine. It captures each finished result on the rising edge of the engine's `eoc`, optionally averages groups of 2^AVG_LOG2 results, and queues the averages in a small FIFO with a valid/ready output handshake toward the digital back-end. It reports lost results through a sticky overflow flag.

## Interface
- AVG_LOG2, 2, log2 of samples per average; legal 0..4; 0 = pass-through.
- DEPTH_LOG2, 2, log2 of FIFO depth (default depth 4 entries).
- clk  in  1  system clock, same clock that drives the SAR engine.
- rst  in  1  reset, asynchronous and active-high.
- clr  in  1  synchronous clear: empties the FIFO, discards any partial group, clears `overflow`.
- sar_in  in  8  conversion result from the SAR engine; stable while `eoc`=1.
- eoc  in  1  end-of-conversion level from the SAR engine; may stay high for several cycles.
- out_data  out  8  FIFO head; forced to 0 when `out_valid`=0.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts the head when `out_valid`=1.
- fill  out  DEPTH_LOG2+1  number of occupied entries.
- overflow  out  1  sticky; set when a completed average is dropped.

## Operation
- Edge detect: register `eoc` into `eoc_d`. A capture occurs on a clock edge where `eoc`=1 and `eoc_d`=0. Exactly one capture per high pulse, whatever its length.
- Accumulator `acc`, width 8+AVG_LOG2 bits. Sample counter `cnt`, width AVG_LOG2 bits.
- On a capture with `cnt` < 2^AVG_LOG2−1: `acc` <= `acc`+`sar_in`, and `cnt` increments.
- On a capture with `cnt` = 2^AVG_LOG2−1, the group is complete:
  - push value = (`acc`+`sar_in`) >> AVG_LOG2, truncating.
  - `acc` <= 0 and `cnt` <= 0.
- AVG_LOG2=0: every capture pushes `sar_in` directly.
- FIFO: circular buffer of 2^DEPTH_LOG2 entries with write pointer, read pointer and a `fill` counter.
  - A pop occurs when `out_valid`=1 and `out_ready`=1.
  - `out_ready` while empty is ignored.
- Push while full:
  - If a pop occurs on the same edge, the push is accepted and `fill` stays at full.
  - Otherwise the value is dropped, `overflow` <= 1, and the FIFO is unchanged.
- Push and pop on the same edge at any other fill level: `fill` unchanged, and the head advances to the next entry.
- `clr` has priority over capture, push and pop on that edge. The `eoc_d` register still updates on a `clr` edge.
- `overflow` clears only on `rst` or `clr`.

## Timing
- Reset values:
  - `out_data`=0, `out_valid`=0, `fill`=0, `overflow`=0.
  - `acc`=0, `cnt`=0, `eoc_d`=0, both pointers 0.
- FIFO storage needs no reset.
- Latency: the push happens on the capture edge. `out_valid` and `out_data` reflect the new entry immediately after that edge, i.e. 1 cycle after `eoc` is first sampled high, provided the FIFO was empty.
- `out_valid`, `out_data` and `fill` are derived directly from registers. No combinational path from `out_ready` to `out_data`; the next head appears after the pop edge.
- Throughput: one capture per 2 cycles maximum, because `eoc` must return low between pulses. The FIFO sustains one push plus one pop per cycle.
- `rst` asserted mid-group or mid-burst: state clears asynchronously and the partial group is lost. After release, the next capture starts a new group with `cnt`=0.
- `eoc` already high when `rst` releases: `eoc_d`=0, so this counts as a rising edge and is captured on the first edge.

## Test plan
- Pass-through (AVG_LOG2=0), `out_ready`=1, 3 `eoc` pulses with `sar_in`=0x5A, 0x00, 0xFF:
  - `out_data` shows 0x5A, 0x00, 0xFF in order, each 1 cycle after its capture.
  - `overflow`=0.
- Averaging (AVG_LOG2=2), samples 10, 11, 12, 13:
  - single entry 11 (46>>2); `fill`=1 after the 4th capture and 0 before it.
  - Then four samples of 255: entry 255, no accumulator wrap.
- Long `eoc` (AVG_LOG2=0): hold `eoc` high 6 cycles with `sar_in`=0x33 → exactly one entry, `fill`=1.
- Overflow (AVG_LOG2=0, DEPTH 4), `out_ready`=0, 5 pulses 1..5:
  - `fill`=4 and `overflow`=1 after the 5th.
  - Draining yields 1, 2, 3, 4.
  - `overflow` stays 1 until `clr`.
- Full with simultaneous pop: fill to 4, then on the 5th capture edge hold `out_ready`=1:
  - `fill` stays 4 and `overflow`=0.
  - Drain order is 2, 3, 4, 5.
- Reset/clear mid-group (AVG_LOG2=2):
  - Capture 100 and 100, pulse `rst`, then capture 4, 4, 4, 4 → single entry 4.
  - Repeat using `clr` instead of `rst`: same result, and the FIFO is empty immediately after `clr`.
